mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 256-bit main-memory line port between the instruction cache (refill reads only)
//  and the data cache (refill reads and line write-backs). One owner per transaction; the grant is held
//  until the memory returns i_mem_ready. Sits between both caches and the memory controller.
// PARAMETERS
//  LINE_BITS     256  width of one cache line / memory transfer
//  ADDR_BITS     32   address width
//  STARVE_LIMIT  4    max consecutive DC grants while an IC request waits; the next grant is then forced to IC
// PORTS
//  clock          in   1          system clock, rising edge
//  reset          in   1          asynchronous, active-low reset (0 = reset)
//  i_ic_address   in   ADDR_BITS  IC refill address
//  i_ic_read      in   1          IC refill request, level, held until o_ic_ready
//  o_ic_data      out  LINE_BITS  refill line to IC
//  o_ic_ready     out  1          1-cycle pulse: o_ic_data valid
//  i_dc_address   in   ADDR_BITS  DC address
//  i_dc_read      in   1          DC refill request, level
//  i_dc_write     in   1          DC write-back request, level
//  i_dc_data      in   LINE_BITS  DC write-back line
//  o_dc_data      out  LINE_BITS  refill line to DC
//  o_dc_ready     out  1          1-cycle pulse: read data valid / write accepted
//  o_mem_address  out  ADDR_BITS  line-aligned address, bits [4:0] forced to 0
//  o_mem_read     out  1          memory read strobe, level
//  o_mem_write    out  1          memory write strobe, level
//  o_mem_data     out  LINE_BITS  write-back line
//  i_mem_data     in   LINE_BITS  read data, valid with i_mem_ready
//  i_mem_ready    in   1          1-cycle pulse: memory finished the current transfer
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, owner NONE, starve counter 0, every output 0.
//  FSM (all outputs registered):
//   IDLE  : if any request, latch owner/op/address/wdata -> BUSY. Priority DC>IC unless starve==STARVE_LIMIT.
//   BUSY  : drive o_mem_* from latched values until i_mem_ready. On ready: copy i_mem_data to the
//           owner's data output (reads only), pulse owner ready next cycle, drop o_mem_* -> RELEASE.
//   RELEASE: one idle cycle, all o_mem_* = 0, ready pulse visible; lets the requester drop its level.
//           -> IDLE. No grant is made in RELEASE.
//  Latency: request sampled at edge N, o_mem_* high after edge N+1; i_mem_ready at edge M gives
//   o_*_ready high for exactly cycle M+1. Minimum request-to-ready is 3 cycles with 0-wait memory.
//  Starvation: on a DC grant while i_ic_read=1, starve++ (saturates at STARVE_LIMIT); on IC grant or IC idle, starve=0.
//  Simultaneous i_dc_read & i_dc_write: treated as write-back; read is ignored this transaction.
//  Requester deasserts mid-BUSY: no abort; transfer completes, ready still pulses, data still driven.
//  i_mem_ready in IDLE/RELEASE: ignored. Address/data changes after grant: ignored (latched copy used).
//  o_ic_data/o_dc_data hold the last line until the next read to that port or reset.
//  Reset asserted mid-BUSY: immediate return to IDLE, strobes drop; memory must tolerate the abort.
// STRUCTURE
//  pkg_defines: typedef enum {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_e;
//   typedef enum {OWN_NONE, OWN_IC, OWN_DC} mem_owner_e; localparam LINE_BITS shared with both caches.
//  No sub-module; the FSM, owner/op latches and starve counter are inline in one always_ff.
// TESTING
//  1 IC read 0x0000_1044 alone, mem ready 2 cycles later with 0xA5..A5 -> o_mem_address=0x0000_1040,
//    o_mem_read=1 until ready, o_ic_ready 1 cycle, o_ic_data=0xA5..A5, o_dc_ready stays 0.
//  2 IC read and DC read raised same cycle -> DC granted first, IC granted right after RELEASE; two pulses in order.
//  3 DC reads back-to-back with IC pending, STARVE_LIMIT=4 -> exactly 4 DC grants, 5th grant goes to IC.
//  4 DC write 0x0000_2000 with data 0x1234.. -> o_mem_write=1, o_mem_data=0x1234.., o_mem_read=0,
//    o_dc_ready pulse, o_dc_data unchanged.
//  5 DC read and write both high -> write-back only; IC drops i_ic_read mid-BUSY -> transfer completes, ready pulses.
//  6 reset low for 1 cycle mid-BUSY -> all outputs 0 asynchronously, IDLE after release; fresh request served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the cache-to-memory line port arbiter.
package mem_port_arbiter_pkg;
  localparam int ARB_LINE_BITS    = 256;
  localparam int ARB_ADDR_BITS    = 32;
  localparam int ARB_STARVE_LIMIT = 4;
  localparam int LINE_OFS_BITS    = 5;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC}        mem_owner_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory line port between IC refills and DC refills/write-backs.
// One transaction at a time; grant held until memory ready, then one release cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_BITS    = ARB_LINE_BITS,
  parameter int ADDR_BITS    = ARB_ADDR_BITS,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] i_ic_address,
  input  logic                 i_ic_read,
  output logic [LINE_BITS-1:0] o_ic_data,
  output logic                 o_ic_ready,
  input  logic [ADDR_BITS-1:0] i_dc_address,
  input  logic                 i_dc_read,
  input  logic                 i_dc_write,
  input  logic [LINE_BITS-1:0] i_dc_data,
  output logic [LINE_BITS-1:0] o_dc_data,
  output logic                 o_dc_ready,
  output logic [ADDR_BITS-1:0] o_mem_address,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [LINE_BITS-1:0] o_mem_data,
  input  logic [LINE_BITS-1:0] i_mem_data,
  input  logic                 i_mem_ready
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'((1 << LINE_OFS_BITS) - 1);

  arb_state_e           state, state_n;
  mem_owner_e           owner;
  logic                 op_wr;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [LINE_BITS-1:0] lat_wdata;
  logic [SW-1:0]        starve;

  logic dc_req, starved, grant_ic, grant_dc, strobe_on, mem_done;

  assign dc_req    = i_dc_read | i_dc_write;
  assign starved   = (starve == SW'(STARVE_LIMIT));
  assign strobe_on = o_mem_read | o_mem_write;
  // Ready only counts once the strobe is actually on the bus.
  assign mem_done  = strobe_on & i_mem_ready;

  always_comb begin
    state_n  = state;
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (i_ic_read && (starved || !dc_req)) grant_ic = 1'b1;
        else if (dc_req)                       grant_dc = 1'b1;
        if (grant_ic || grant_dc) state_n = ARB_BUSY;
      end
      ARB_BUSY:    if (mem_done) state_n = ARB_RELEASE;
      ARB_RELEASE: state_n = ARB_IDLE;
      default:     state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ARB_IDLE;
      owner         <= OWN_NONE;
      op_wr         <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      starve        <= '0;
      o_ic_data     <= '0;
      o_ic_ready    <= 1'b0;
      o_dc_data     <= '0;
      o_dc_ready    <= 1'b0;
      o_mem_address <= '0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_data    <= '0;
    end else begin
      state      <= state_n;
      o_ic_ready <= 1'b0;
      o_dc_ready <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_ic) begin
            owner     <= OWN_IC;
            op_wr     <= 1'b0;
            lat_addr  <= i_ic_address & ALIGN_MASK;
            lat_wdata <= '0;
            starve    <= '0;
          end else if (grant_dc) begin
            // A simultaneous read+write request is served as the write-back.
            owner     <= OWN_DC;
            op_wr     <= i_dc_write;
            lat_addr  <= i_dc_address & ALIGN_MASK;
            lat_wdata <= i_dc_data;
            starve    <= !i_ic_read ? '0 : (starved ? starve : starve + SW'(1));
          end
        end
        ARB_BUSY: begin
          if (mem_done) begin
            o_mem_address <= '0;
            o_mem_read    <= 1'b0;
            o_mem_write   <= 1'b0;
            o_mem_data    <= '0;
            if (owner == OWN_IC) begin
              o_ic_ready <= 1'b1;
              if (!op_wr) o_ic_data <= i_mem_data;
            end else if (owner == OWN_DC) begin
              o_dc_ready <= 1'b1;
              if (!op_wr) o_dc_data <= i_mem_data;
            end
          end else begin
            o_mem_address <= lat_addr;
            o_mem_read    <= !op_wr;
            o_mem_write   <= op_wr;
            o_mem_data    <= op_wr ? lat_wdata : '0;
          end
        end
        ARB_RELEASE: owner <= OWN_NONE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timestamp-based transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int LB = 256;
  localparam int AB = 32;
  localparam int SL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AB-1:0] i_ic_address, i_dc_address, o_mem_address;
  logic          i_ic_read, i_dc_read, i_dc_write, i_mem_ready;
  logic [LB-1:0] i_dc_data, i_mem_data, o_ic_data, o_dc_data, o_mem_data;
  logic          o_ic_ready, o_dc_ready, o_mem_read, o_mem_write;

  always #5 clock = ~clock;

  mem_port_arbiter #(.LINE_BITS(LB), .ADDR_BITS(AB), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .i_ic_address(i_ic_address), .i_ic_read(i_ic_read),
    .o_ic_data(o_ic_data), .o_ic_ready(o_ic_ready),
    .i_dc_address(i_dc_address), .i_dc_read(i_dc_read), .i_dc_write(i_dc_write),
    .i_dc_data(i_dc_data), .o_dc_data(o_dc_data), .o_dc_ready(o_dc_ready),
    .o_mem_address(o_mem_address), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data), .i_mem_ready(i_mem_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LB-1:0] line_of(input logic [AB-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  // Memory responder: raises ready after mem_wait+1 strobe cycles.
  int            mem_wait = 0;
  int            rcnt = 0;
  bit            use_fixed = 0;
  logic [LB-1:0] fixed_line = '0;
  int            spur_req = 0;
  int            spur_done = 0;
  always @(negedge clock) begin
    if (!reset) begin
      i_mem_ready = 1'b0;
      rcnt = 0;
    end else if (spur_req != spur_done) begin
      i_mem_ready = 1'b1;
      i_mem_data  = '1;
      spur_done   = spur_req;
    end else if ((o_mem_read || o_mem_write) && !i_mem_ready) begin
      rcnt++;
      if (rcnt > mem_wait) begin
        i_mem_ready = 1'b1;
        i_mem_data  = use_fixed ? fixed_line : line_of(o_mem_address);
        rcnt = 0;
      end
    end else begin
      i_mem_ready = 1'b0;
      i_mem_data  = ~line_of(o_mem_address);
    end
  end

  // Transaction logs: strobe starts and ready pulses (1 = IC, 0 = DC).
  typedef struct {
    logic [AB-1:0] addr;
    logic          rd;
    logic          wr;
    logic [LB-1:0] data;
  } xfer_t;
  xfer_t slog[$];
  bit    order[$];
  bit    prev_strobe = 0;
  always @(negedge clock) begin
    if ((o_mem_read || o_mem_write) && !prev_strobe)
      slog.push_back('{o_mem_address, o_mem_read, o_mem_write, o_mem_data});
    prev_strobe = o_mem_read || o_mem_write;
  end

  // Model: one transaction described by grant edge g and completion edge done.
  int            cyc = 0, m_g = 0, m_done = -1, m_starve = 0;
  bit            m_has = 0, m_ic = 0, m_wr = 0;
  logic [AB-1:0] m_addr = '0;
  logic [LB-1:0] m_wdata = '0, m_icd = '0, m_dcd = '0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc = 0; m_has = 0; m_done = -1; m_starve = 0; m_icd = '0; m_dcd = '0;
    end else begin
      cyc++;
      if (m_has && m_done < 0 && cyc >= m_g + 2 && i_mem_ready) begin
        m_done = cyc;
        if (!m_wr) begin
          if (m_ic) m_icd = i_mem_data;
          else      m_dcd = i_mem_data;
        end
      end else if ((!m_has || (m_done >= 0 && cyc >= m_done + 2)) &&
                   (i_ic_read || i_dc_read || i_dc_write)) begin
        m_has = 1; m_g = cyc; m_done = -1;
        m_ic = i_ic_read && (m_starve == SL || !(i_dc_read || i_dc_write));
        if (m_ic) begin
          m_wr = 0; m_addr = i_ic_address & ~32'h1F; m_starve = 0;
        end else begin
          m_wr = i_dc_write; m_addr = i_dc_address & ~32'h1F; m_wdata = i_dc_data;
          m_starve = !i_ic_read ? 0 : (m_starve < SL ? m_starve + 1 : SL);
        end
      end
    end
  end

  always @(negedge clock) begin
    bit strobe, pulse;
    strobe = m_has && cyc >= m_g + 1 && (m_done < 0 || cyc < m_done);
    pulse  = m_has && m_done >= 0 && cyc == m_done;
    chk("cyc_mem_read",  LB'(o_mem_read),    LB'(strobe && !m_wr));
    chk("cyc_mem_write", LB'(o_mem_write),   LB'(strobe && m_wr));
    chk("cyc_mem_addr",  LB'(o_mem_address), strobe ? LB'(m_addr) : '0);
    chk("cyc_mem_data",  o_mem_data,         (strobe && m_wr) ? m_wdata : '0);
    chk("cyc_ic_ready",  LB'(o_ic_ready),    LB'(pulse && m_ic));
    chk("cyc_dc_ready",  LB'(o_dc_ready),    LB'(pulse && !m_ic));
    chk("cyc_ic_data",   o_ic_data,          m_icd);
    chk("cyc_dc_data",   o_dc_data,          m_dcd);
  end

  // Requester behaviour: drop levels on ready, optionally re-request from DC.
  int dc_repeat = 0;
  task automatic step();
    @(negedge clock);
    if (o_ic_ready) begin
      order.push_back(1'b1);
      i_ic_read = 1'b0;
    end
    if (o_dc_ready) begin
      order.push_back(1'b0);
      if (dc_repeat > 0) begin
        dc_repeat--;
        i_dc_address = i_dc_address + 32'h40;
      end else begin
        i_dc_read = 1'b0; i_dc_write = 1'b0;
      end
    end
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((i_ic_read || i_dc_read || i_dc_write || o_mem_read || o_mem_write ||
            o_ic_ready || o_dc_ready) && n < max) begin
      step(); n++;
    end
    if (n >= max) begin
      checks++; errors++;
      $display("FAIL %s timeout after %0d cycles", name, n);
    end
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (!(o_mem_read || o_mem_write) && n < 50) begin step(); n++; end
    chk({name, "_strobe_seen"}, LB'(o_mem_read || o_mem_write), LB'(1));
  endtask

  initial begin
    int lat, ic_pos;
    reset = 1'b0;
    i_ic_address = '0; i_ic_read = 0; i_dc_address = '0; i_dc_read = 0;
    i_dc_write = 0; i_dc_data = '0;
    repeat (2) @(negedge clock);
    chk("rst_mem_read", LB'(o_mem_read), '0);
    chk("rst_ic_data",  o_ic_data, '0);
    chk("rst_dc_ready", LB'(o_dc_ready), '0);
    reset = 1'b1;

    // 1: lone IC read, ready in the second strobe cycle.
    mem_wait = 1; use_fixed = 1; fixed_line = {32{8'hA5}};
    order.delete(); slog.delete();
    i_ic_address = 32'h0000_1044; i_ic_read = 1;
    lat = 0;
    while (order.size() == 0 && lat < 50) begin step(); lat++; end
    chk("t1_latency", LB'(lat), LB'(4));
    chk("t1_addr", LB'(slog[0].addr), LB'(32'h0000_1040));
    chk("t1_rd",   LB'({slog[0].rd, slog[0].wr}), LB'(2'b10));
    chk("t1_ic_data", o_ic_data, {32{8'hA5}});
    chk("t1_no_dc", LB'(order.size() == 1 && order[0] == 1'b1), LB'(1));
    drain("t1", 50);
    use_fixed = 0;

    // 2: simultaneous IC and DC reads, DC first.
    mem_wait = 0; order.delete();
    i_ic_address = 32'h3000; i_ic_read = 1;
    i_dc_address = 32'h4000; i_dc_read = 1;
    drain("t2", 100);
    chk("t2_count", LB'(order.size()), LB'(2));
    chk("t2_order", LB'({order[0], order[1]}), LB'(2'b01));
    chk("t2_ic_data", o_ic_data, line_of(32'h3000));
    chk("t2_dc_data", o_dc_data, line_of(32'h4000));

    // 3: DC streaming with IC pending; IC must win the fifth grant.
    order.delete();
    i_ic_address = 32'h3100; i_ic_read = 1;
    i_dc_address = 32'h4100; i_dc_read = 1; dc_repeat = 5;
    drain("t3", 300);
    ic_pos = -1;
    foreach (order[k]) if (order[k] && ic_pos < 0) ic_pos = k;
    chk("t3_count", LB'(order.size()), LB'(7));
    chk("t3_ic_pos", LB'(ic_pos), LB'(4));
    chk("t3_dc_data", o_dc_data, line_of(32'h4240));
    chk("t3_ic_data", o_ic_data, line_of(32'h3100));

    // 4: stray ready while idle, then DC write-back.
    spur_req++;
    step(); step();
    chk("t4_idle_ready_ignored", LB'({o_dc_ready, o_ic_ready, o_mem_read}), '0);
    order.delete(); slog.delete();
    i_dc_address = 32'h2000; i_dc_data = {8{32'h1234_5678}}; i_dc_write = 1;
    drain("t4", 50);
    chk("t4_wr",   LB'({slog[0].rd, slog[0].wr}), LB'(2'b01));
    chk("t4_addr", LB'(slog[0].addr), LB'(32'h2000));
    chk("t4_data", slog[0].data, {8{32'h1234_5678}});
    chk("t4_pulse", LB'(order.size() == 1 && order[0] == 1'b0), LB'(1));
    chk("t4_dc_data_kept", o_dc_data, line_of(32'h4240));

    // 5: read+write together is a write-back; IC drops its request mid-transfer.
    slog.delete();
    i_dc_address = 32'h5008; i_dc_data = {8{32'hCAFE_F00D}}; i_dc_read = 1; i_dc_write = 1;
    drain("t5a", 50);
    chk("t5_wr_only", LB'({slog[0].rd, slog[0].wr}), LB'(2'b01));
    chk("t5_addr", LB'(slog[0].addr), LB'(32'h5000));
    chk("t5_dc_data_kept", o_dc_data, line_of(32'h4240));
    mem_wait = 3; order.delete();
    i_ic_address = 32'h6000; i_ic_read = 1;
    wait_strobe("t5");
    i_ic_read = 0;
    drain("t5b", 50);
    chk("t5_ic_pulse", LB'(order.size() == 1 && order[0] == 1'b1), LB'(1));
    chk("t5_ic_data", o_ic_data, line_of(32'h6000));

    // 6: async reset mid-transfer, then a fresh request.
    mem_wait = 5;
    i_ic_address = 32'h7000; i_ic_read = 1;
    wait_strobe("t6");
    #2 reset = 1'b0;
    #1;
    chk("t6_async_strobe", LB'({o_mem_read, o_mem_write}), '0);
    chk("t6_async_addr", LB'(o_mem_address), '0);
    chk("t6_async_ic_data", o_ic_data, '0);
    i_ic_read = 0;
    @(negedge clock);
    reset = 1'b1;
    mem_wait = 0; order.delete();
    i_dc_address = 32'h8000; i_dc_read = 1;
    drain("t6", 50);
    chk("t6_dc_pulse", LB'(order.size() == 1 && order[0] == 1'b0), LB'(1));
    chk("t6_dc_data", o_dc_data, line_of(32'h8000));

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
